ibus_arbiter: RTL and testbench
===============================

Name: ibus_arbiter

Overview:
- Shares the 16-bit I/O bus (ibus_ren/radr/rdata, ibus_wen/wadr/wdata) between two masters: m0 = CPU DMA engine, m1 = debug/monitor master.
- One transaction per grant; round-robin fairness.
- Sits between the CPU top-level ibus outputs and the peripheral bus decoder.
- All bus-side outputs are registered.

Parameters:
- RD_LAT, 1, cycles from ibus_ren strobe to valid ibus_rdata (legal 1..4)
- AW, 18, address width; addresses are bits [19:2]

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 request; holds until granted
- m0_we  in  1  master 0: 1=write, 0=read
- m0_adr  in  18  master 0 address [19:2]
- m0_wdata  in  16  master 0 write data
- m0_gnt  out  1  master 0 accept pulse; fields captured this cycle
- m0_rdata  out  16  master 0 read data
- m0_rvalid  out  1  master 0 read data valid pulse
- m1_req, m1_we, m1_adr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: same as m0, for master 1
- ibus_ren  out  1  bus read strobe
- ibus_radr  out  18  bus read address [19:2]
- ibus_rdata  in  16  bus read data
- ibus_wen  out  1  bus write strobe
- ibus_wadr  out  18  bus write address [19:2]
- ibus_wdata  out  16  bus write data
- busy  out  1  arbiter not in IDLE

Behaviour:
- Clocking: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; priority pointer = m0; latched fields 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - mN_gnt is combinational: asserted when in IDLE, mN_req=1, and N wins arbitration.
  - Tie-break: the pointer master wins.
  - On the grant edge: capture we/adr/wdata and owner; pointer moves to the other master; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Read: ibus_ren=1, ibus_radr=captured adr; go to WAIT with counter=RD_LAT.
  - Write: ibus_wen=1, ibus_wadr/ibus_wdata=captured; go to IDLE.
- WAIT:
  - Counter decrements each cycle.
  - At the edge where counter reaches 1: sample ibus_rdata into owner's mN_rdata; go to IDLE.
  - mN_rvalid pulses 1 cycle, coincident with the return to IDLE.
- mN_rdata holds its value until the next read for that master.
- Timing with RD_LAT=1:
  - Read: gnt cycle 0, ren cycle 1, WAIT cycle 2, rvalid cycle 3. A new grant is possible in cycle 3.
  - Write: gnt cycle 0, wen cycle 1, next grant cycle 2.
- Masters may withdraw req before gnt; no grant is issued and no side effect occurs.
- No grant is issued outside IDLE. req held during a busy period is served in order by the pointer.
- Both masters requesting continuously get strict alternation, starting with m0 after reset.
- ibus_ren and ibus_wen are never both high in the same cycle.
- Strobes are never asserted for more than 1 cycle per transaction.
- busy = (state != IDLE).
- Reset asserted mid-transaction: immediate return to IDLE and all outputs 0. An in-flight read is dropped with no rvalid.

Optional Feature:
- Macro: IBUS_ARB_LOCK_EN.
- Defined:
  - Adds inputs m0_lock, m1_lock.
  - If the granted master has lock=1 at gnt, the pointer is not rotated.
  - While the lock owner's lock stays 1, IDLE grants only that master; the other master is blocked even if the owner's req=0.
  - Lock release is sampled in IDLE; the pointer then moves to the other master.
  - Used for DMA read-modify-write bursts.
- Undefined: no lock ports; pure round-robin as above.

Decomposition:
- Shared include ibus_arb_defs.vh:
  - state encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2
  - address width constant
  - RD_LAT legal range check
- One sub-module: rr_pick2, a 2-way round-robin picker.
  - Inputs: req[1:0], pointer.
  - Outputs: one-hot win[1:0].
  - Purely combinational.
- The top level holds the FSM, capture registers and latency counter.

Test Plan:
- m0 read adr 18'h00100, ibus_rdata=16'hA5A5 one cycle after ren (RD_LAT=1) -> m0_gnt c0, ibus_ren c1 with radr 18'h00100, m0_rvalid c3 with m0_rdata=16'hA5A5, m1 outputs unchanged.
- m0 and m1 request writes simultaneously from reset, held 4 transactions each -> wen order m0,m1,m0,m1..., one wen every 2 cycles, wdata and wadr match each owner.
- RD_LAT=3, m1 read -> ren at c1, rdata sampled at end of c4, m1_rvalid at c5; m0_req raised at c2 gets gnt at c5.
- Assert rst_n=0 during WAIT -> all outputs 0 immediately, no rvalid after release, next request granted to m0 first.
- m1_req pulsed 1 cycle while busy, withdrawn before IDLE -> no m1_gnt, no bus strobe.
- With IBUS_ARB_LOCK_EN: m0_lock=1 over 3 writes while m1_req=1 -> 3 consecutive m0 grants, m1 granted the first IDLE cycle after m0_lock drops.

Source files
------------

// File: rtl/ibus_arbiter_pkg.sv
// Shared definitions for the I/O bus arbiter: FSM encodings, bus widths and
// the legal read-latency range.
package ibus_arbiter_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  localparam int unsigned AddrWidth = 18;
  localparam int unsigned DataWidth = 16;

  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 4;

  // True when a read latency fits the 3-bit wait counter and bus timing.
  function automatic bit rd_lat_ok(input int unsigned lat);
    return (lat >= RdLatMin) && (lat <= RdLatMax);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. pointer selects the master that wins a tie
// (0 = master 0, 1 = master 1). Purely combinational, one-hot output.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] win
);

  // A master wins if it requests and either the other is idle or it holds priority.
  always_comb begin
    win    = 2'b00;
    win[0] = req[0] & (~req[1] | ~pointer);
    win[1] = req[1] & (~req[0] |  pointer);
  end

endmodule

// File: rtl/ibus_arbiter.sv
// Arbiter sharing the 16-bit I/O bus between the DMA engine (m0) and the
// debug/monitor master (m1). One transaction per grant, round-robin priority,
// registered bus-side outputs.
// Optional: define IBUS_ARB_LOCK_EN to add m0_lock/m1_lock, which pin the
// grant to one master for read-modify-write bursts.
module ibus_arbiter
  import ibus_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = AddrWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [AW-1:0]        m0_adr,
  input  logic [DataWidth-1:0] m0_wdata,
  output logic                 m0_gnt,
  output logic [DataWidth-1:0] m0_rdata,
  output logic                 m0_rvalid,

  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [AW-1:0]        m1_adr,
  input  logic [DataWidth-1:0] m1_wdata,
  output logic                 m1_gnt,
  output logic [DataWidth-1:0] m1_rdata,
  output logic                 m1_rvalid,

`ifdef IBUS_ARB_LOCK_EN
  input  logic                 m0_lock,
  input  logic                 m1_lock,
`endif

  output logic                 ibus_ren,
  output logic [AW-1:0]        ibus_radr,
  input  logic [DataWidth-1:0] ibus_rdata,
  output logic                 ibus_wen,
  output logic [AW-1:0]        ibus_wadr,
  output logic [DataWidth-1:0] ibus_wdata,
  output logic                 busy
);

  if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_bad
    $error("ibus_arbiter: RD_LAT must be within 1..4");
  end

  logic [1:0]           state_q;
  logic                 ptr_q;
  logic                 owner_q;
  logic                 we_q;
  logic [2:0]           cnt_q;
  logic                 ren_q, wen_q;
  logic [AW-1:0]        radr_q, wadr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [DataWidth-1:0] m0_rdata_q, m1_rdata_q;
  logic                 m0_rvalid_q, m1_rvalid_q;

  logic [1:0]           req_vec;
  logic                 ptr_eff;
  logic [1:0]           win;
  logic [1:0]           gnt_vec;
  logic                 grant;
  logic                 gsel;
  logic                 g_we;
  logic [AW-1:0]        g_adr;
  logic [DataWidth-1:0] g_wdata;

`ifdef IBUS_ARB_LOCK_EN
  logic lock_act_q;
  logic lock_own_q;
  logic owner_lock;
  logic g_lock;
`endif

  rr_pick2 u_pick (
    .req     (req_vec),
    .pointer (ptr_eff),
    .win     (win)
  );

  // Arbitration inputs, grant decode and selection of the winner's fields.
  always_comb begin
    req_vec = {m1_req, m0_req};
    ptr_eff = ptr_q;
`ifdef IBUS_ARB_LOCK_EN
    owner_lock = lock_own_q ? m1_lock : m0_lock;
    g_lock     = 1'b0;
    if (lock_act_q) begin
      // Held lock masks the other master; a dropped lock hands priority over
      // in the same IDLE cycle.
      if (owner_lock) req_vec = req_vec & (lock_own_q ? 2'b10 : 2'b01);
      else            ptr_eff = ~lock_own_q;
    end
`endif
    gnt_vec = (state_q == StIdle) ? win : 2'b00;
    grant   = |gnt_vec;
    gsel    = gnt_vec[1];
    g_we    = gsel ? m1_we    : m0_we;
    g_adr   = gsel ? m1_adr   : m0_adr;
    g_wdata = gsel ? m1_wdata : m0_wdata;
`ifdef IBUS_ARB_LOCK_EN
    g_lock  = gsel ? m1_lock  : m0_lock;
`endif
  end

  // FSM, capture registers, latency counter and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 3'd0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      radr_q      <= '0;
      wadr_q      <= '0;
      wdata_q     <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
`ifdef IBUS_ARB_LOCK_EN
      lock_act_q  <= 1'b0;
      lock_own_q  <= 1'b0;
`endif
    end else begin
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
`ifdef IBUS_ARB_LOCK_EN
          if (lock_act_q && !owner_lock) begin
            lock_act_q <= 1'b0;
            ptr_q      <= ~lock_own_q;
          end
`endif
          if (grant) begin
            state_q <= StIssue;
            owner_q <= gsel;
            we_q    <= g_we;
`ifdef IBUS_ARB_LOCK_EN
            if (g_lock) begin
              ptr_q      <= gsel;
              lock_act_q <= 1'b1;
              lock_own_q <= gsel;
            end else begin
              ptr_q      <= ~gsel;
              lock_act_q <= 1'b0;
            end
`else
            ptr_q   <= ~gsel;
`endif
            if (g_we) begin
              wen_q   <= 1'b1;
              wadr_q  <= g_adr;
              wdata_q <= g_wdata;
            end else begin
              ren_q   <= 1'b1;
              radr_q  <= g_adr;
            end
          end
        end
        StIssue: begin
          if (we_q) begin
            state_q <= StIdle;
          end else begin
            state_q <= StWait;
            cnt_q   <= 3'(RD_LAT);
          end
        end
        StWait: begin
          if (cnt_q == 3'd1) begin
            state_q <= StIdle;
            if (owner_q) begin
              m1_rdata_q  <= ibus_rdata;
              m1_rvalid_q <= 1'b1;
            end else begin
              m0_rdata_q  <= ibus_rdata;
              m0_rvalid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m0_gnt     = gnt_vec[0];
  assign m1_gnt     = gnt_vec[1];
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;
  assign m0_rvalid  = m0_rvalid_q;
  assign m1_rvalid  = m1_rvalid_q;
  assign ibus_ren   = ren_q;
  assign ibus_radr  = radr_q;
  assign ibus_wen   = wen_q;
  assign ibus_wadr  = wadr_q;
  assign ibus_wdata = wdata_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ibus_arbiter.sv
// Directed bench for ibus_arbiter. Two instances share the master-side
// stimulus: u_dut (RD_LAT=1) and u_dut3 (RD_LAT=3). Bus transactions of
// u_dut are checked against a scoreboard queue filled when stimulus is driven.
module tb_ibus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [17:0] m0_adr = '0, m1_adr = '0;
  logic [15:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_lock = 0, m1_lock = 0;
  logic [15:0] rd_val = '0;

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ibus_ren, ibus_wen, busy;
  logic [15:0] m0_rdata, m1_rdata, ibus_wdata, ibus_rdata;
  logic [17:0] ibus_radr, ibus_wadr;

  logic        d3_m0_gnt, d3_m1_gnt, d3_m0_rvalid, d3_m1_rvalid, d3_ren, d3_wen, d3_busy;
  logic [15:0] d3_m0_rdata, d3_m1_rdata, d3_wdata, d3_rdata;
  logic [17:0] d3_radr, d3_wadr;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [17:0] adr;
    logic [15:0] data;
  } bus_t;
  bus_t sb[$];

  ibus_arbiter #(.RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
`ifdef IBUS_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .ibus_ren(ibus_ren), .ibus_radr(ibus_radr), .ibus_rdata(ibus_rdata),
    .ibus_wen(ibus_wen), .ibus_wadr(ibus_wadr), .ibus_wdata(ibus_wdata),
    .busy(busy)
  );

  ibus_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_gnt(d3_m0_gnt), .m0_rdata(d3_m0_rdata), .m0_rvalid(d3_m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_gnt(d3_m1_gnt), .m1_rdata(d3_m1_rdata), .m1_rvalid(d3_m1_rvalid),
`ifdef IBUS_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .ibus_ren(d3_ren), .ibus_radr(d3_radr), .ibus_rdata(d3_rdata),
    .ibus_wen(d3_wen), .ibus_wadr(d3_wadr), .ibus_wdata(d3_wdata),
    .busy(d3_busy)
  );

  // Bus model: read data is valid only RD_LAT cycles after the ren strobe.
  logic       ren1_dly;
  logic [2:0] ren3_sh;
  always @(posedge clk) begin
    ren1_dly <= ibus_ren;
    ren3_sh  <= {ren3_sh[1:0], d3_ren};
  end
  assign ibus_rdata = ren1_dly   ? rd_val : 16'hDEAD;
  assign d3_rdata   = ren3_sh[2] ? rd_val : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [17:0] adr, input logic [15:0] data);
    bus_t e;
    e.we = we; e.adr = adr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(); rst_n = 1'b0;
    cyc(); cyc(); rst_n = 1'b1;
  endtask

  // Scoreboard monitor on u_dut's bus side.
  always @(negedge clk) begin
    bus_t e;
    if (rst_n && (ibus_ren || ibus_wen)) begin
      chk("strobe_excl", 32'(ibus_ren & ibus_wen), 32'd0);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("bus_we", 32'(ibus_wen), 32'(e.we));
        chk("bus_adr", 32'(ibus_wen ? ibus_wadr : ibus_radr), 32'(e.adr));
        if (ibus_wen) chk("bus_wdata", 32'(ibus_wdata), 32'(e.data));
      end
    end
  end

  initial begin
    int i0, i1;
    logic g0, g1;

    // Reset state
    cyc(); cyc();
    neg();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ren", 32'(ibus_ren), 32'd0);
    chk("rst_wen", 32'(ibus_wen), 32'd0);
    chk("rst_radr", 32'(ibus_radr), 32'd0);
    chk("rst_m0_rdata", 32'(m0_rdata), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    cyc(); rst_n = 1'b1;

    // m0 read, RD_LAT=1
    cyc(); rd_val = 16'hA5A5;
    m0_req = 1; m0_we = 0; m0_adr = 18'h00100; push(1'b0, 18'h00100, 16'h0);
    neg(); chk("t1_m0_gnt_c0", 32'(m0_gnt), 32'd1); chk("t1_m1_gnt_c0", 32'(m1_gnt), 32'd0);
    cyc(); m0_req = 0;
    neg(); chk("t1_ren_c1", 32'(ibus_ren), 32'd1); chk("t1_busy_c1", 32'(busy), 32'd1);
    cyc();
    neg(); chk("t1_rvalid_c2", 32'(m0_rvalid), 32'd0);
    cyc();
    neg(); chk("t1_rvalid_c3", 32'(m0_rvalid), 32'd1);
    chk("t1_rdata_c3", 32'(m0_rdata), 32'hA5A5);
    chk("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("t1_m1_rdata", 32'(m1_rdata), 32'd0);
    chk("t1_idle_c3", 32'(busy), 32'd0);
    repeat (8) cyc();

    // Simultaneous writes from reset: strict alternation starting at m0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(1'b1, 18'h01000 + 18'(k), 16'h1000 + 16'(k));
      push(1'b1, 18'h02000 + 18'(k), 16'h2000 + 16'(k));
    end
    i0 = 0; i1 = 0;
    cyc();
    m0_req = 1; m0_we = 1; m0_adr = 18'h01000; m0_wdata = 16'h1000;
    m1_req = 1; m1_we = 1; m1_adr = 18'h02000; m1_wdata = 16'h2000;
    for (int c = 0; c < 16; c++) begin
      neg();
      g0 = m0_gnt; g1 = m1_gnt;
      chk("t2_m0_gnt", 32'(g0), 32'(c % 4 == 0));
      chk("t2_m1_gnt", 32'(g1), 32'(c % 4 == 2));
      cyc();
      if (g0) begin
        i0++;
        if (i0 == 4) m0_req = 0;
        else begin m0_adr = 18'h01000 + 18'(i0); m0_wdata = 16'h1000 + 16'(i0); end
      end
      if (g1) begin
        i1++;
        if (i1 == 4) m1_req = 0;
        else begin m1_adr = 18'h02000 + 18'(i1); m1_wdata = 16'h2000 + 16'(i1); end
      end
    end
    chk("t2_m0_count", 32'(i0), 32'd4);
    chk("t2_m1_count", 32'(i1), 32'd4);
    repeat (4) cyc();

    // RD_LAT=3 read by m1 (u_dut3); m0 read request arrives during the wait
    do_reset();
    push(1'b0, 18'h00300, 16'h0);
    push(1'b0, 18'h00400, 16'h0);
    cyc(); rd_val = 16'h3C3C; m1_req = 1; m1_we = 0; m1_adr = 18'h00300;
    neg(); chk("t3_m1_gnt_c0", 32'(d3_m1_gnt), 32'd1);
    cyc(); m1_req = 0;
    neg(); chk("t3_ren_c1", 32'(d3_ren), 32'd1); chk("t3_radr_c1", 32'(d3_radr), 32'h00300);
    cyc(); m0_req = 1; m0_we = 0; m0_adr = 18'h00400;
    neg(); chk("t3_m0_gnt_c2", 32'(d3_m0_gnt), 32'd0);
    cyc();
    neg(); chk("t3_m0_gnt_c3", 32'(d3_m0_gnt), 32'd0);
    cyc();
    neg(); chk("t3_rvalid_c4", 32'(d3_m1_rvalid), 32'd0);
    chk("t3_m0_gnt_c4", 32'(d3_m0_gnt), 32'd0); chk("t3_busy_c4", 32'(d3_busy), 32'd1);
    cyc();
    neg(); chk("t3_rvalid_c5", 32'(d3_m1_rvalid), 32'd1);
    chk("t3_rdata_c5", 32'(d3_m1_rdata), 32'h3C3C);
    chk("t3_m0_gnt_c5", 32'(d3_m0_gnt), 32'd1);
    cyc(); m0_req = 0;
    repeat (8) cyc();

    // Reset during WAIT drops the read; pointer returns to m0
    cyc(); m0_req = 1; m0_we = 0; m0_adr = 18'h00500; push(1'b0, 18'h00500, 16'h0);
    neg(); chk("t4_m0_gnt", 32'(m0_gnt), 32'd1);
    cyc(); m0_req = 0;
    cyc();
    neg(); chk("t4_busy_wait", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_rvalid", 32'(m0_rvalid), 32'd0);
    chk("t4_rst_rdata", 32'(m0_rdata), 32'd0);
    chk("t4_rst_radr", 32'(ibus_radr), 32'd0);
    chk("t4_rst_d3_busy", 32'(d3_busy), 32'd0);
    cyc(); rst_n = 1'b1;
    repeat (3) begin
      neg(); chk("t4_no_rvalid", 32'(m0_rvalid), 32'd0);
      cyc();
    end
    push(1'b1, 18'h00700, 16'h7070);
    push(1'b1, 18'h00800, 16'h8080);
    m0_req = 1; m0_we = 1; m0_adr = 18'h00700; m0_wdata = 16'h7070;
    m1_req = 1; m1_we = 1; m1_adr = 18'h00800; m1_wdata = 16'h8080;
    neg(); chk("t4_m0_first", 32'(m0_gnt), 32'd1); chk("t4_m1_not_first", 32'(m1_gnt), 32'd0);
    cyc(); m0_req = 0;
    cyc();
    neg(); chk("t4_m1_second", 32'(m1_gnt), 32'd1);
    cyc(); m1_req = 0;
    repeat (4) cyc();

    // m1 request pulsed while busy and withdrawn: no grant, no strobe
    m0_req = 1; m0_we = 1; m0_adr = 18'h00600; m0_wdata = 16'h6666;
    push(1'b1, 18'h00600, 16'h6666);
    neg(); chk("t5_m0_gnt", 32'(m0_gnt), 32'd1);
    cyc(); m0_req = 0; m1_req = 1; m1_we = 1; m1_adr = 18'h00900;
    neg(); chk("t5_m1_gnt_busy", 32'(m1_gnt), 32'd0);
    cyc(); m1_req = 0;
    repeat (3) begin
      neg();
      chk("t5_m1_gnt", 32'(m1_gnt), 32'd0);
      chk("t5_no_strobe", 32'(ibus_ren | ibus_wen), 32'd0);
      cyc();
    end

`ifdef IBUS_ARB_LOCK_EN
    // Locked m0 burst keeps m1 out until the lock drops
    do_reset();
    for (int k = 0; k < 3; k++) push(1'b1, 18'h03000 + 18'(k), 16'h3000 + 16'(k));
    push(1'b1, 18'h04000, 16'h4000);
    i0 = 0;
    cyc();
    m0_req = 1; m0_lock = 1; m0_we = 1; m0_adr = 18'h03000; m0_wdata = 16'h3000;
    m1_req = 1; m1_we = 1; m1_adr = 18'h04000; m1_wdata = 16'h4000;
    for (int c = 0; c < 7; c++) begin
      neg();
      g0 = m0_gnt;
      chk("t6_m0_gnt", 32'(g0), 32'(c % 2 == 0 && c < 6));
      chk("t6_m1_blocked", 32'(m1_gnt), 32'd0);
      cyc();
      if (g0) begin
        i0++;
        if (i0 == 3) m0_req = 0;
        else begin m0_adr = 18'h03000 + 18'(i0); m0_wdata = 16'h3000 + 16'(i0); end
      end
    end
    m0_lock = 0;
    neg(); chk("t6_m1_after_unlock", 32'(m1_gnt), 32'd1);
    cyc(); m1_req = 0;
    repeat (4) cyc();
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
